// File: rtl/mod_inverse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mod_inverse
//  Purpose  : x = a^-1 mod p for odd p via binary extended Euclid, one step
//             per clock, with valid/ready stream operands and result.
//  Revision : 1.0  initial release
// ============================================================================
module mod_inverse #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_a_tdata,
  input  logic            input_a_tvalid,
  output logic            input_a_tready,
  input  logic [SIZE-1:0] input_modulus_tdata,
  input  logic            input_modulus_tvalid,
  output logic            input_modulus_tready,
  output logic [SIZE-1:0] output_tdata,
  output logic            output_tuser,
  output logic            output_tvalid,
  input  logic            output_tready
);

  localparam logic [1:0]      c_S_IDLE = 2'd0;
  localparam logic [1:0]      c_S_RUN  = 2'd1;
  localparam logic [1:0]      c_S_OUT  = 2'd2;
  localparam logic [SIZE-1:0] c_ZERO   = '0;
  localparam logic [SIZE-1:0] c_ONE    = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] c_THREE  = {{(SIZE-2){1'b0}}, 2'b11};

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] u_q, u_d;
  logic [SIZE-1:0] v_q, v_d;
  logic [SIZE-1:0] x1_q, x1_d;
  logic [SIZE-1:0] x2_q, x2_d;
  logic [SIZE-1:0] p_q, p_d;
  logic [SIZE-1:0] res_q, res_d;
  logic            err_q, err_d;

  logic w_accept;
  logic w_illegal;

  // x/2 mod p: an odd x gets p added first, carried at SIZE+1 bits.
  function automatic logic [SIZE-1:0] half_mod(input logic [SIZE-1:0] x,
                                               input logic [SIZE-1:0] p);
    logic [SIZE:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
    return s[SIZE:1];
  endfunction

  // (a - b) mod p for a, b already in [0, p-1]
  function automatic logic [SIZE-1:0] sub_mod(input logic [SIZE-1:0] a,
                                              input logic [SIZE-1:0] b,
                                              input logic [SIZE-1:0] p);
    return (a >= b) ? (a - b) : (p - (b - a));
  endfunction

  assign w_accept  = (state_q == c_S_IDLE) & input_a_tvalid & input_modulus_tvalid & ~rst;
  assign w_illegal = ~input_modulus_tdata[0] | (input_modulus_tdata < c_THREE) |
                     (input_a_tdata == c_ZERO) | (input_a_tdata >= input_modulus_tdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_S_IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      p_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      p_q     <= p_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    p_d     = p_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      c_S_IDLE: begin
        if (w_accept) begin
          u_d  = input_a_tdata;
          v_d  = input_modulus_tdata;
          x1_d = c_ONE;
          x2_d = c_ZERO;
          p_d  = input_modulus_tdata;
          if (w_illegal) begin
            res_d   = c_ZERO;
            err_d   = 1'b1;
            state_d = c_S_OUT;
          end else begin
            err_d   = 1'b0;
            state_d = c_S_RUN;
          end
        end
      end
      c_S_RUN: begin
        // Rule order matters: termination tests precede any reduction step.
        if (u_q == c_ONE) begin
          res_d   = x1_q;
          err_d   = 1'b0;
          state_d = c_S_OUT;
        end else if (v_q == c_ONE) begin
          res_d   = x2_q;
          err_d   = 1'b0;
          state_d = c_S_OUT;
        end else if ((u_q == c_ZERO) || (v_q == c_ZERO)) begin
          res_d   = c_ZERO;
          err_d   = 1'b1;
          state_d = c_S_OUT;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q, p_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q, p_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q, p_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q, p_q);
        end
      end
      c_S_OUT: begin
        if (output_tready) begin
          state_d = c_S_IDLE;
        end
      end
      default: begin
        state_d = c_S_IDLE;
      end
    endcase
  end

  always_comb begin
    input_a_tready       = w_accept;
    input_modulus_tready = w_accept;
    output_tvalid        = (state_q == c_S_OUT);
    output_tdata         = res_q;
    output_tuser         = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_inverse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mod_inverse
//  Purpose  : Scoreboard bench for mod_inverse: directed vectors, backpressure,
//             reset mid-run and random odd moduli against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_inverse;

  localparam int SIZE    = 64;
  localparam int LAT_MAX = 4*SIZE + 3;
  localparam int N_RAND  = 120;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] input_a_tdata;
  logic            input_a_tvalid;
  logic            input_a_tready;
  logic [SIZE-1:0] input_modulus_tdata;
  logic            input_modulus_tvalid;
  logic            input_modulus_tready;
  logic [SIZE-1:0] output_tdata;
  logic            output_tuser;
  logic            output_tvalid;
  logic            output_tready;

  always #5 clk = ~clk;

  mod_inverse #(.SIZE(SIZE)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_a_tdata        (input_a_tdata),
    .input_a_tvalid       (input_a_tvalid),
    .input_a_tready       (input_a_tready),
    .input_modulus_tdata  (input_modulus_tdata),
    .input_modulus_tvalid (input_modulus_tvalid),
    .input_modulus_tready (input_modulus_tready),
    .output_tdata         (output_tdata),
    .output_tuser         (output_tuser),
    .output_tvalid        (output_tvalid),
    .output_tready        (output_tready)
  );

  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] p;
    logic [SIZE-1:0] x;
    logic            err;
    int              lat;
    int              acc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: extended Euclid on wide signed values, plus the operand legality rules.
  function automatic logic [SIZE:0] ref_inv(input logic [SIZE-1:0] a, input logic [SIZE-1:0] p);
    logic signed [2*SIZE+1:0] r0, r1, s0, s1, q, t;
    if (!p[0] || (p < 3) || (a == 0) || (a >= p)) return {1'b1, {SIZE{1'b0}}};
    r0 = a; r1 = p; s0 = 1; s1 = 0;
    while (r1 != 0) begin
      q  = r0 / r1;
      t  = r0 - q * r1; r0 = r1; r1 = t;
      t  = s0 - q * s1; s0 = s1; s1 = t;
    end
    if (r0 != 1) return {1'b1, {SIZE{1'b0}}};
    if (s0 < 0) s0 = s0 + p;
    return {1'b0, s0[SIZE-1:0]};
  endfunction

  // Output monitor: pops the scoreboard on each transfer.
  always @(negedge clk) begin
    logic [2*SIZE-1:0] prod;
    int lat;
    if (!rst && output_tvalid) begin
      chk("in_rdy_busy", {63'd0, input_a_tready | input_modulus_tready}, 64'd0);
      if (sbq.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          lat  = cyc - sbq[0].acc;
          if (sbq[0].lat != 0) chk("latency", 64'(lat), 64'(sbq[0].lat));
          else                 chk("lat_bound", {63'd0, lat <= LAT_MAX}, 64'd1);
        end
        if (!output_tready) begin
          chk("stall_data", output_tdata, sbq[0].x);
          chk("stall_user", {63'd0, output_tuser}, {63'd0, sbq[0].err});
        end else begin
          chk("data", output_tdata, sbq[0].x);
          chk("user", {63'd0, output_tuser}, {63'd0, sbq[0].err});
          if (!sbq[0].err) begin
            prod = {{SIZE{1'b0}}, sbq[0].a} * {{SIZE{1'b0}}, output_tdata};
            prod = prod % {{SIZE{1'b0}}, sbq[0].p};
            chk("prod", prod[SIZE-1:0], 64'd1);
          end
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] p, input int xlat,
                      input bit use_ref, input logic [SIZE-1:0] ex, input logic eu);
    exp_t e;
    logic [SIZE:0] r;
    int n;
    @(posedge clk); #1;
    input_a_tdata        = a;
    input_modulus_tdata  = p;
    input_a_tvalid       = 1'b1;
    input_modulus_tvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (input_a_tready && input_modulus_tready) break;
      n++;
      if (n > 3000) break;
    end
    if (!(input_a_tready && input_modulus_tready)) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (use_ref) begin
        r  = ref_inv(a, p);
        ex = r[SIZE-1:0];
        eu = r[SIZE];
      end
      e.a = a; e.p = p; e.x = ex; e.err = eu; e.lat = xlat; e.acc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    input_a_tvalid       = 1'b0;
    input_modulus_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    logic [SIZE-1:0] a, p;
    int n, r;
    rst                  = 1'b1;
    input_a_tdata        = 64'd3;
    input_modulus_tdata  = 64'd7;
    input_a_tvalid       = 1'b1;
    input_modulus_tvalid = 1'b1;
    output_tready        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {63'd0, output_tvalid}, 64'd0);
    chk("rst_tdata", output_tdata, 64'd0);
    chk("rst_tuser", {63'd0, output_tuser}, 64'd0);
    chk("rst_rdy", {62'd0, input_a_tready, input_modulus_tready}, 64'd0);
    input_a_tvalid       = 1'b0;
    input_modulus_tvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Directed vectors
    send(64'd3,     64'd7,     0, 1'b0, 64'd5,     1'b0);
    drain();
    send(64'd1,     64'd7,     2, 1'b0, 64'd1,     1'b0);
    drain();
    send(64'd3,     64'd65537, 0, 1'b0, 64'd21846, 1'b0);
    drain();
    send(64'd65536, 64'd65537, 0, 1'b0, 64'd65536, 1'b0);
    drain();
    send(64'd6,     64'd9,     0, 1'b0, 64'd0,     1'b1);
    drain();
    send(64'd3,     64'd8,     1, 1'b0, 64'd0,     1'b1);
    drain();
    send(64'd0,     64'd7,     1, 1'b0, 64'd0,     1'b1);
    drain();
    send(64'd7,     64'd7,     1, 1'b0, 64'd0,     1'b1);
    drain();
    send(64'd2,     64'd1,     1, 1'b0, 64'd0,     1'b1);
    drain();

    // Backpressure with the next operands already waiting
    output_tready = 1'b0;
    send(64'd3, 64'd7, 0, 1'b0, 64'd5, 1'b0);
    n = 0;
    while (!output_tvalid && n < 500) begin @(negedge clk); n++; end
    chk("bp_valid_seen", {63'd0, output_tvalid}, 64'd1);
    input_a_tdata        = 64'd65536;
    input_modulus_tdata  = 64'd65537;
    input_a_tvalid       = 1'b1;
    input_modulus_tvalid = 1'b1;
    repeat (10) @(posedge clk);
    #1 output_tready = 1'b1;
    send(64'd65536, 64'd65537, 0, 1'b0, 64'd65536, 1'b0);
    drain();

    // Lone a-valid must not be taken
    @(posedge clk); #1;
    input_a_tdata  = 64'd3;
    input_a_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lone_a_rdy", {62'd0, input_a_tready, input_modulus_tready}, 64'd0);
    end
    @(posedge clk); #1 input_a_tvalid = 1'b0;

    // Reset in the middle of a long run
    send(64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFC5, 0, 1'b1, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", {63'd0, output_tvalid}, 64'd0);
    chk("midrst_tuser", {63'd0, output_tuser}, 64'd0);
    sbq.delete();
    seen = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    send(64'd2, 64'd11, 0, 1'b0, 64'd6, 1'b0);
    drain();

    // Random odd moduli, occasional illegal operands
    for (int i = 0; i < N_RAND; i++) begin
      p = {$urandom, $urandom} | 64'd1;
      if (i % 4 == 0) p = 64'($urandom_range(3, 255) | 1);
      r = $urandom_range(0, 19);
      if (r == 0)      a = 64'd0;
      else if (r == 1) a = p;
      else             a = {$urandom, $urandom} % p;
      send(a, p, 0, 1'b1, 64'd0, 1'b0);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
